// File: rtl/icache_param.sv
// icache_param: VIPT set-associative icache with tree-PLRU refill, uncached bypass, flush; ports clk/reset, ireq_*/iresp_* fetch side, creq_*/cresp_* burst bus side
module icache_param #(
  parameter int SETS = 64,
  parameter int WAYS = 4,
  parameter int LINE_WORDS = 8,
  parameter int FETCH_WORDS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq_valid,
  input  logic [31:0] ireq_vaddr,
  input  logic [31:0] ireq_paddr,
  input  logic ireq_uncached,
  input  logic invalidate,
  output logic iresp_addr_ok,
  output logic iresp_data_ok,
  output logic [32*FETCH_WORDS-1:0] iresp_data,
  output logic iresp_err,
  output logic creq_valid,
  output logic [31:0] creq_addr,
  output logic [7:0] creq_len,
  input  logic cresp_ready,
  input  logic cresp_last,
  input  logic [31:0] cresp_data
);
  localparam int OFF = $clog2(LINE_WORDS*4);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32-IDX-OFF;
  localparam int GOFF = $clog2(FETCH_WORDS*4);
  localparam int LW = $clog2(WAYS);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int WB = OFF-2;
  localparam int LB = LINE_WORDS*32;
  localparam int GB = FETCH_WORDS*32;
  localparam logic [WB-1:0] GMASK = ~WB'(FETCH_WORDS-1);
  typedef enum logic [2:0] {FLUSH, RUN, REFILL, UNC, RESP} state_t;
  state_t r_state;
  logic [WAYS-1:0] r_valid [SETS];
  logic [TAG-1:0] r_tag [SETS][WAYS];
  logic [LB-1:0] r_line [SETS][WAYS];
  logic [WAYS-2:0] r_plru [SETS];
  logic [IDX-1:0] r_cnt, r_idx;
  logic [BW-1:0] r_beat;
  logic [LW-1:0] r_vic;
  logic [LB-1:0] r_fill;
  logic [31:0] r_paddr;
  logic r_s2v, r_unc, r_inv;
  logic [WAYS-1:0] w_match;
  logic [LW-1:0] w_hway, w_vic;
  logic [LB-1:0] w_fill, w_hline;
  logic [WB-1:0] w_word;
  logic w_hit, w_mis, w_done, w_miss, w_inv, w_last, w_unused;
  function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] t);
    int n = 1;
    for (int l = 0; l < LW; l++) n = 2*n + int'(t[n-1]);
    return LW'(n - WAYS);
  endfunction
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [LW-1:0] w);
    int n = 1;
    for (int l = 0; l < LW; l++) begin
      t[n-1] = ~w[LW-1-l];
      n = 2*n + int'(w[LW-1-l]);
    end
    return t;
  endfunction
  always_comb begin
    w_match = '0;
    w_hway = '0;
    w_vic = plru_victim(r_plru[r_idx]);
    for (int i = 0; i < WAYS; i++) w_match[i] = r_valid[r_idx][i] && r_tag[r_idx][i] == r_paddr[31:IDX+OFF];
    for (int i = WAYS-1; i >= 0; i--) begin
      if (w_match[i]) w_hway = LW'(i);
      if (!r_valid[r_idx][i]) w_vic = LW'(i);
    end
    w_fill = r_fill;
    if (cresp_ready) w_fill[r_beat*32 +: 32] = cresp_data;
  end
  assign w_unused = ^{ireq_vaddr[31:IDX+OFF], ireq_vaddr[OFF-1:0]};
  assign w_hit = |w_match;
  assign w_mis = |r_paddr[1:0];
  assign w_hline = r_line[r_idx][w_hway];
  assign w_word = r_paddr[OFF-1:2] & GMASK;
  assign w_done = r_state == RUN && r_s2v && (w_mis || (!r_unc && w_hit));
  assign w_miss = r_state == RUN && r_s2v && !w_mis && (r_unc || !w_hit);
  assign w_inv = r_inv || invalidate;
  assign w_last = cresp_ready && cresp_last;
  assign iresp_addr_ok = ireq_valid && r_state == RUN && !w_inv && (!r_s2v || (w_done && !w_mis));
  assign iresp_data_ok = w_done || r_state == RESP;
  assign iresp_err = w_done && w_mis;
  assign iresp_data = r_state == RESP ? (r_unc ? r_fill[GB-1:0] : r_fill[w_word*32 +: GB]) :
                      (w_done && !w_mis) ? w_hline[w_word*32 +: GB] : '0;
  assign creq_valid = r_state == REFILL || r_state == UNC;
  assign creq_addr = r_state == REFILL ? {r_paddr[31:OFF], OFF'(0)} : r_state == UNC ? {r_paddr[31:GOFF], GOFF'(0)} : '0;
  assign creq_len = r_state == REFILL ? 8'(LINE_WORDS-1) : r_state == UNC ? 8'(FETCH_WORDS-1) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FLUSH;
      r_cnt <= '0;
      r_beat <= '0;
      r_s2v <= 1'b0;
      r_inv <= 1'b0;
    end else begin
      r_inv <= (r_state == RUN && !w_miss) ? 1'b0 : w_inv;
      if (iresp_addr_ok) begin
        r_s2v <= 1'b1;
        r_paddr <= ireq_paddr;
        r_idx <= ireq_vaddr[IDX+OFF-1:OFF];
        r_unc <= ireq_uncached;
      end else if (w_done || r_state == RESP) r_s2v <= 1'b0;
      if (w_done && !w_mis) r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_hway);
      if ((r_state == REFILL || r_state == UNC) && cresp_ready) begin
        r_fill <= w_fill;
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
      case (r_state)
        FLUSH: begin
          r_valid[r_cnt] <= '0;
          r_plru[r_cnt] <= '0;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX'(SETS-1)) r_state <= RUN;
        end
        RUN: begin
          if (w_miss && !r_unc) r_vic <= w_vic;
          r_state <= w_miss ? (r_unc ? UNC : REFILL) : w_inv ? FLUSH : RUN;
        end
        REFILL: if (w_last) begin
          r_line[r_idx][r_vic] <= w_fill;
          r_tag[r_idx][r_vic] <= r_paddr[31:IDX+OFF];
          r_valid[r_idx][r_vic] <= 1'b1;
          r_plru[r_idx] <= plru_touch(r_plru[r_idx], r_vic);
          r_state <= RESP;
        end
        UNC: if (w_last) r_state <= RESP;
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: doc/icache_param.md
# icache_param

Parametrised, set-associative, VIPT instruction cache between the fetch stage and the crossbar. It performs a 2-stage lookup: set index from the virtual address, tag from the physical address. Misses refill one full line by burst and choose the victim with tree pseudo-LRU. An uncached bypass, whole-cache invalidate and a misalignment error response are built in.

## Interface
Parameters:
- SETS, 64: number of sets, power of 2.
- WAYS, 4: associativity, power of 2, at least 2.
- LINE_WORDS, 8: 32-bit words per line, power of 2.
- FETCH_WORDS, 2: words returned per fetch. Power of 2, at most LINE_WORDS.
- Derived widths:
  - OFF = log2(LINE_WORDS*4), IDX = log2(SETS), TAG = 32-IDX-OFF.
  - IDX+OFF must be at most 12 (VIPT alias-free).

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: synchronous, active-high.
- ireq_valid, in, 1: fetch request.
- ireq_vaddr, in, 32: virtual address, supplies the index.
- ireq_paddr, in, 32: physical address, supplies the tag. Must be stable while ireq_valid is high.
- ireq_uncached, in, 1: bypass the cache for this request.
- invalidate, in, 1: pulse that clears all valid bits.
- iresp_addr_ok, out, 1: request accepted this cycle.
- iresp_data_ok, out, 1: response valid, single cycle.
- iresp_data, out, 32*FETCH_WORDS: fetch group. Word 0 is in the LSBs.
- iresp_err, out, 1: misaligned request. Qualified by data_ok.
- creq_valid, out, 1: bus read request.
- creq_addr, out, 32: burst base address.
- creq_len, out, 8: beats-1.
- cresp_ready, in, 1: data beat valid.
- cresp_last, in, 1: final beat.
- cresp_data, in, 32: beat data.

## Operation
- Fetch group: aligned to FETCH_WORDS*4 bytes. The low log2(FETCH_WORDS*4) address bits select nothing.
- Acceptance: iresp_addr_ok = ireq_valid & state==RUN & (stage 2 empty, or stage 2 is a cached hit).
- Stage 1 (accept cycle):
  - Meta RAM, data RAM and PLRU are read at vaddr[IDX+OFF-1:OFF].
  - paddr, uncached flag and misalignment flag are latched into stage 2.
- Stage 2:
  - Hit if any way has valid=1 and a tag equal to paddr[31:IDX+OFF]. Hits are one-hot; a multiple hit is a bench error.
  - Hit: data_ok=1, data = words at paddr[OFF-1:2] aligned down to the group. PLRU is updated to mark the hit way MRU.
  - Misaligned (paddr[1:0]≠0): data_ok=1, err=1, data=0. No bus traffic, no state change.
  - Miss, cached: go to REFILL.
  - Uncached: go to UNC.
- Victim selection: lowest-numbered invalid way; otherwise the PLRU tree victim. Latched on entry to REFILL.
- States:
  - FLUSH: counter walks sets 0..SETS-1, clearing valid bits and PLRU, one set per cycle. Then RUN. addr_ok=0 throughout.
  - RUN: normal pipelined lookup.
  - REFILL:
    - Bus request: creq_valid=1, creq_addr = {paddr[31:OFF], OFF'b0}, creq_len = LINE_WORDS-1.
    - Each cresp_ready beat writes the fill buffer at the beat counter, then increments the counter.
    - On the beat with cresp_last:
      - data RAM line, meta (tag, valid=1) and PLRU (victim becomes MRU) are written at the latched index;
      - go to RESP.
  - RESP: data_ok=1 with the group selected from the fill buffer. Stage 2 is cleared; go to RUN.
  - UNC:
    - Bus request: creq_valid=1, creq_addr = paddr aligned to the group, creq_len = FETCH_WORDS-1.
    - Beats are collected into the fill buffer. After last, go to RESP.
    - No RAM or PLRU writes.
- Invalidate:
  - Sampled in any state. Recorded as pending.
  - It takes effect when the FSM next reaches RUN with stage 2 empty or completing: go to FLUSH.
  - An in-flight refill completes and responds first.
- Reset: go to FLUSH.

## Timing
- Reset values:
  - all outputs 0;
  - state FLUSH, set counter 0, beat counter 0, stage 2 empty, invalidate-pending 0.
- addr_ok first rises SETS cycles after reset deasserts.
- Hit latency: data_ok the cycle after addr_ok. Throughput is 1 fetch per cycle on consecutive hits.
- Miss latency: the cycle after the last beat (RESP). Minimum LINE_WORDS+2 cycles after addr_ok with zero-wait bus.
- creq_valid and creq_addr stay constant from REFILL/UNC entry until the cycle of cresp_last inclusive. They drop to 0 in RESP.
- A hit on the same set in the cycle right after a refill's RESP reads the new line, because the RAM write completes before the read.
- A beat counter overflow (more than LINE_WORDS beats without last) wraps modulo LINE_WORDS; the result is undefined.
- Reset mid-REFILL: bus outputs drop the next cycle and the partial line is discarded.

## Test plan
- Reset, then hold ireq_valid with paddr=0x1000 → addr_ok low 64 cycles; then REFILL with creq_addr=0x1000, len=7. Feed beats 0xA0..0xA7 → data_ok with data={0xA1,0xA0}.
- Cold miss at 0x1008, then back-to-back requests 0x1000 and 0x1018 → both hit. Data_ok on consecutive cycles, data {0xA1,0xA0} and {0xA7,0xA6}.
- Five distinct tags in set 0 (0x0000, 0x0800, 0x1000, 0x1800, 0x2000; set stride SETS*LINE_WORDS*4 = 0x800) → fifth fill evicts way 0. Re-access 0x0000 → misses; 0x0800 still hits.
- Uncached 0xBFC00004 → creq_addr=0xBFC00000, len=1. No RAM write; a repeat access misses the bus again.
- paddr=0x1002 → data_ok=1, err=1, data=0, creq_valid never asserted.
- Pulse invalidate during a refill → the refill's response is delivered, then 64 FLUSH cycles; the next access to 0x1000 misses.
